// File: rtl/window_ctrl.sv
// Frame sequencer for a 3x3 sliding-window line buffer: paces upstream pixels,
// tracks row/col, and flags windows whose bottom-right pixel has row>=2 and col>=2.
module window_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 3,
    parameter int HEIGHT     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [DATA_WIDTH-1:0]       o_lb_data,
    output logic                        o_lb_valid,
    output logic                        o_win_valid,
    input  logic                        i_out_ready,
    output logic [$clog2(HEIGHT)-1:0]   o_win_row,
    output logic [$clog2(WIDTH)-1:0]    o_win_col,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            win_valid_q, win_valid_d;
    logic [RW-1:0]   win_row_q, win_row_d;
    logic [CW-1:0]   win_col_q, win_col_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic accept;
    logic consume;
    logic last_pix;

    // A held, unconsumed window blocks upstream so the line buffer cannot shift under it.
    assign o_ready     = (state_q == RUN) && (!win_valid_q || i_out_ready);
    assign accept      = i_valid && o_ready;
    assign consume     = win_valid_q && i_out_ready;
    assign last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign o_lb_valid  = accept;
    assign o_lb_data   = i_data;

    assign o_win_valid = win_valid_q;
    assign o_win_row   = win_row_q;
    assign o_win_col   = win_col_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    win_row_d   = row_q;
                    win_col_d   = col_q;
                    // Gating on col>=2 drops the wrap-around windows; row>=2 hides stale buffer rows.
                    win_valid_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (!last_pix) row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_pix) state_d = DRAIN;
                end else if (consume) begin
                    win_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (consume) begin
                    win_valid_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl: a 4x4 instance for the main frames and a 3x3
// instance for the minimum-size frame, sharing the input stimulus.
module tb_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_out_ready;

    logic       a_ready, a_lb_valid, a_win_valid, a_busy, a_done;
    logic [7:0] a_lb_data;
    logic [1:0] a_win_row, a_win_col;
    logic       b_ready, b_lb_valid, b_win_valid, b_busy, b_done;
    logic [7:0] b_lb_data;
    logic [1:0] b_win_row, b_win_col;

    logic       w_ready, w_lb_valid, w_win_valid, w_busy, w_done;
    logic [7:0] w_lb_data;
    logic [1:0] w_win_row, w_win_col;

    int sel = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    window_ctrl #(.DATA_WIDTH(8), .WIDTH(4), .HEIGHT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .i_data(i_data), .i_valid(i_valid),
        .o_ready(a_ready), .o_lb_data(a_lb_data), .o_lb_valid(a_lb_valid),
        .o_win_valid(a_win_valid), .i_out_ready(i_out_ready),
        .o_win_row(a_win_row), .o_win_col(a_win_col), .o_busy(a_busy), .o_done(a_done)
    );

    window_ctrl #(.DATA_WIDTH(8), .WIDTH(3), .HEIGHT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .i_data(i_data), .i_valid(i_valid),
        .o_ready(b_ready), .o_lb_data(b_lb_data), .o_lb_valid(b_lb_valid),
        .o_win_valid(b_win_valid), .i_out_ready(i_out_ready),
        .o_win_row(b_win_row), .o_win_col(b_win_col), .o_busy(b_busy), .o_done(b_done)
    );

    always_comb begin
        if (sel == 0) begin
            w_ready = a_ready; w_lb_valid = a_lb_valid; w_win_valid = a_win_valid;
            w_busy = a_busy; w_done = a_done; w_lb_data = a_lb_data;
            w_win_row = a_win_row; w_win_col = a_win_col;
        end else begin
            w_ready = b_ready; w_lb_valid = b_lb_valid; w_win_valid = b_win_valid;
            w_busy = b_busy; w_done = b_done; w_lb_data = b_lb_data;
            w_win_row = b_win_row; w_win_col = b_win_col;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win_valid"}, w_win_valid, 0);
        check({tag, "_win_row"}, w_win_row, 0);
        check({tag, "_win_col"}, w_win_col, 0);
        check({tag, "_done"}, w_done, 0);
        check({tag, "_busy"}, w_busy, 0);
        check({tag, "_ready"}, w_ready, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", w_busy, 1);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One frame, cycle by cycle. Expected window k sits at row 2+k/(w-2), col 2+k%(w-2).
    task automatic run_frame(input int w, input int h, input bit gap, input int stall,
                             input int stop_after, input bit poke_start);
        int  pix = 0, nwin = 0, cyc = 0, stall_left = 0, acc_edge = -10, edge_n = 0;
        int  total;
        bit  done_seen = 0, first_seen = 0, acc;
        total = (stop_after > 0) ? stop_after : w * h;
        while (!done_seen && !(stop_after > 0 && pix == stop_after)) begin
            if (cyc >= 400) begin
                check("frame_timeout", cyc, 0);
                break;
            end
            i_valid     = (pix < total) && (!gap || (cyc % 2 == 0));
            i_data      = 8'(pix);
            i_out_ready = (stall_left == 0);
            start       = poke_start && (cyc == 5);
            #1;
            check("run_busy", w_busy, 1);
            if (stall_left > 0) begin
                check("stall_ready", w_ready, 0);
                check("stall_lb_valid", w_lb_valid, 0);
                check("stall_win_valid", w_win_valid, 1);
                check("stall_win_row", w_win_row, 2);
                check("stall_win_col", w_win_col, 2);
                stall_left--;
            end
            if (w_win_valid && i_out_ready) begin
                check("win_row", w_win_row, 2 + nwin / (w - 2));
                check("win_col", w_win_col, 2 + nwin % (w - 2));
                nwin++;
            end
            acc = w_lb_valid;
            if (acc) check("lb_data", w_lb_data, pix);
            @(posedge clk); #1;
            edge_n++;
            cyc++;
            if (acc) begin
                pix++;
                acc_edge = edge_n;
            end
            if (w_win_valid && !first_seen) begin
                first_seen = 1;
                check("first_win_pixel", pix - 1, 2 * w + 2);
                stall_left = stall;
            end
            if (w_done) done_seen = 1;
        end
        i_valid = 1'b0;
        start   = 1'b0;
        if (stop_after == 0) begin
            check("done_after_last_accept", edge_n - acc_edge, 1);
            check("pixels_accepted", pix, w * h);
            check("window_count", nwin, (w - 2) * (h - 2));
            @(posedge clk); #1;
            check("done_one_cycle", w_done, 0);
            check("idle_busy", w_busy, 0);
            check("idle_ready", w_ready, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; i_data = '0; i_valid = 1'b0; i_out_ready = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        @(posedge clk); #1;
        check_reset_outputs("por_clk");
        rst = 1'b0;

        // Pixels offered while idle must not shift the line buffer.
        i_valid = 1'b1; i_data = 8'd55;
        #1;
        check("idle_ready_in", w_ready, 0);
        check("idle_lb_valid", w_lb_valid, 0);
        @(posedge clk); #1;
        check("idle_stays_idle", w_busy, 0);
        i_valid = 1'b0;

        do_start();
        run_frame(4, 4, 0, 0, 0, 0);

        do_start();
        run_frame(4, 4, 0, 3, 0, 0);

        do_start();
        run_frame(4, 4, 1, 0, 0, 1);

        // Abandon a frame after pixel 9, which has latched window coordinates (2,1).
        do_start();
        run_frame(4, 4, 0, 0, 10, 0);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_done", w_done, 0);
        end
        rst = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("post_rst_lb_valid", w_lb_valid, 0);
            @(posedge clk); #1;
            check("post_rst_busy", w_busy, 0);
            check("post_rst_done", w_done, 0);
        end
        i_valid = 1'b0;
        do_start();
        run_frame(4, 4, 0, 0, 0, 0);

        // Minimum 3x3 frame on the second instance.
        sel = 1;
        reset_pulse();
        #1 check_reset_outputs("min_rst");
        do_start();
        run_frame(3, 3, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/window_ctrl.md
WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, giving the pixel word width.
REQ-002 The block SHALL provide parameter WIDTH, default 3, giving the image width in pixels (>=3); it SHALL match the line buffer's WIDTH.
REQ-003 The block SHALL provide parameter HEIGHT, default 3, giving the image height in rows (>=3).
REQ-004 The block SHALL have these ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle frame start request.
- i_data  input  DATA_WIDTH  upstream pixel.
- i_valid  input  1  upstream pixel valid.
- o_ready  output  1  upstream ready.
- o_lb_data  output  DATA_WIDTH  pixel to the line buffer i_data.
- o_lb_valid  output  1  shift enable to the line buffer valid_in.
- o_win_valid  output  1  the 3x3 window at the line buffer outputs is valid.
- i_out_ready  input  1  downstream accepts the window.
- o_win_row  output  clog2(HEIGHT)  row of the window's bottom-right pixel.
- o_win_col  output  clog2(WIDTH)  column of the window's bottom-right pixel.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-005 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-006 IDLE->RUN SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-007 o_ready SHALL be 1 only in RUN and only when (o_win_valid=0 or i_out_ready=1), combinationally.
REQ-008 A pixel SHALL be accepted on a rising edge where i_valid=1 and o_ready=1.
REQ-009 o_lb_valid SHALL equal i_valid AND o_ready, and o_lb_data SHALL equal i_data, both combinationally, so the line buffer shifts on the accepting edge.
REQ-010 The col counter SHALL start at 0 and increment on each accept, wrapping WIDTH-1->0.
REQ-011 The row counter SHALL increment when col wraps.
REQ-012 On the accepting edge, o_win_valid SHALL be registered to 1 if the accepted pixel has row>=2 and col>=2.
REQ-013 On that edge, o_win_row/o_win_col SHALL latch the accepted pixel's row/col.
REQ-014 A window SHALL be consumed on an edge where o_win_valid=1 and i_out_ready=1.
REQ-015 o_win_valid SHALL clear on consumption unless a new valid window is registered on the same edge; that simultaneous case SHALL leave it 1 with the new row/col.
REQ-016 While o_win_valid=1 and i_out_ready=0, the block SHALL accept no pixel, o_lb_valid SHALL be 0, and o_win_valid/row/col SHALL hold.
REQ-017 A frame SHALL produce exactly (WIDTH-2)*(HEIGHT-2) windows.
REQ-018 Windows with col<2 (row wrap-around) SHALL never be flagged valid.
REQ-019 Accepting the final pixel (row=HEIGHT-1, col=WIDTH-1) SHALL move RUN->DRAIN.
REQ-020 DRAIN SHALL move to DONE on the edge the final window is consumed.
REQ-021 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-022 row and col SHALL reset to 0 when leaving DONE.
REQ-023 o_busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE and DONE.
REQ-024 i_valid in IDLE, DRAIN or DONE SHALL be ignored: no accept and no line buffer shift.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, row=col=0, o_win_valid=0, o_win_row=0, o_win_col=0, o_done=0, o_busy=0 and o_ready=0, without waiting for a clock.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no o_done pulse.
REQ-027 The next frame after such a reset SHALL require a new start.
REQ-028 The line buffer contents are not cleared by this block; stale data SHALL never be flagged valid, because windows are gated by row>=2.

Verification
REQ-029 Nominal: WIDTH=4, HEIGHT=4, start, then 16 pixels 0..15 with i_valid=1 and i_out_ready=1 -> exactly 4 windows, at (row,col) (2,2),(2,3),(3,2),(3,3); first window with o_data8=10 and o_data0=0; o_done one cycle after the 16th accept.
REQ-030 Backpressure: as REQ-029 with i_out_ready=0 for 3 cycles after the first window -> o_ready=0 and o_lb_valid=0 for those 3 cycles, window (2,2) held stable, no pixel lost, 4 windows total.
REQ-031 Upstream gaps: i_valid toggling 1/0 every cycle -> same 4 windows in order, row/col advance only on accepts, o_busy=1 throughout.
REQ-032 Reset mid-frame: rst pulsed after pixel 9 -> all outputs zero asynchronously, no o_done; after a new start, the frame of REQ-029 completes correctly.
REQ-033 Ignored inputs: start asserted during RUN, and i_valid=1 in IDLE -> no state change, no line buffer shift, o_ready=0 in IDLE.
REQ-034 Minimum size: WIDTH=3, HEIGHT=3, 9 pixels -> exactly one window at (2,2) after the 9th accept, then o_done.
